// File: rtl/quadrature_encoder_tx_pkg.sv
// quadrature_encoder_tx_pkg: shared FSM, phase and Gray-table definitions
package quadrature_encoder_tx_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  typedef logic [1:0] phase_t;
  localparam logic [3:0][1:0] PHASE_AB = {2'b01, 2'b11, 2'b10, 2'b00};
  localparam phase_t STEP_CW = 2'd1;
  localparam phase_t STEP_CCW = 2'd3;
endpackage

// File: rtl/quad_phase_timer.sv
// quad_phase_timer: reloadable down-counter with one-cycle expire
module quad_phase_timer #(
  parameter int PHASE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(PHASE_CYCLES);
  localparam logic [W-1:0] TOP = W'(PHASE_CYCLES - 1);
  localparam logic [W-1:0] ONE = W'(1);
  logic [W-1:0] cnt;
  assign expire = en && cnt == '0;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= TOP;
    else if (en) cnt <= expire ? TOP : cnt - ONE;
endmodule

// File: rtl/quadrature_encoder_tx.sv
// quadrature_encoder_tx: command-driven rotary encoder emulator with position tracking
module quadrature_encoder_tx
  import quadrature_encoder_tx_pkg::*;
#(
  parameter int PHASE_CYCLES = 1000,
  parameter int CNT_W = 8,
  parameter int POS_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [CNT_W-1:0]        cmd_steps,
  output logic                    rotary_a,
  output logic                    rotary_b,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position
);
  localparam logic [CNT_W+1:0] LEFT_ONE = (CNT_W + 2)'(1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  state_t state, state_n;
  phase_t phase, phase_n;
  logic dir, accept, expire, last;
  logic [CNT_W+1:0] left;
  assign accept = cmd_valid && cmd_ready;
  assign phase_n = phase + (dir ? STEP_CW : STEP_CCW);
  assign last = expire && left == LEFT_ONE;
  quad_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .en(state == RUN),
    .expire(expire)
  );
  always_comb begin
    state_n = (state == IDLE && accept && cmd_steps != '0) ? RUN : (state == RUN && last) ? IDLE : state;
    cmd_ready = state == IDLE;
    busy = state == RUN;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      dir <= 1'b0;
      left <= '0;
      rotary_a <= 1'b0;
      rotary_b <= 1'b0;
      done <= 1'b0;
      position <= '0;
    end else begin
      state <= state_n;
      done <= (accept && cmd_steps == '0) || last;
      if (accept) begin
        dir <= cmd_dir;
        left <= {cmd_steps, 2'b00};
      end else if (expire) begin
        phase <= phase_n;
        {rotary_a, rotary_b} <= PHASE_AB[phase_n];
        left <= left - LEFT_ONE;
        if (phase_n == 2'd0) position <= dir ? position + POS_ONE : position - POS_ONE;
      end
    end
endmodule

// File: tb/tb_quadrature_encoder_tx.sv
// tb_quadrature_encoder_tx: directed self-checking bench for quadrature_encoder_tx
module tb_quadrature_encoder_tx;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_dir = 1'b0, cmd_ready, rotary_a, rotary_b, busy, done;
  logic [7:0] cmd_steps = '0;
  logic [15:0] position;
  logic v4 = 1'b0, d4 = 1'b0, ready4, a4, b4, busy4, done4;
  logic [7:0] s4 = '0;
  logic [3:0] pos4;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  quadrature_encoder_tx #(.PHASE_CYCLES(4), .CNT_W(8), .POS_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .rotary_a(rotary_a), .rotary_b(rotary_b), .busy(busy), .done(done),
    .position(position)
  );
  quadrature_encoder_tx #(.PHASE_CYCLES(2), .CNT_W(8), .POS_W(4)) dut4 (
    .clk(clk), .rst(rst), .cmd_valid(v4), .cmd_ready(ready4), .cmd_dir(d4),
    .cmd_steps(s4), .rotary_a(a4), .rotary_b(b4), .busy(busy4), .done(done4),
    .position(pos4)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask
  task automatic issue(input logic d, input logic [7:0] n);
    @(negedge clk);
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_dir = d;
    cmd_steps = n;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask
  task automatic watch(input logic d, input int n);
    for (int k = 0; k <= 16 * n; k++) begin
      int idx;
      logic [1:0] ab;
      @(negedge clk);
      idx = (k / 4) % 4;
      if (!d) idx = (4 - idx) % 4;
      ab = idx == 0 ? 2'b00 : idx == 1 ? 2'b10 : idx == 2 ? 2'b11 : 2'b01;
      chk("ab", {rotary_a, rotary_b}, ab);
      chk("busy", busy, k < 16 * n);
      chk("ready", cmd_ready, k == 16 * n);
      chk("done", done, k == 16 * n);
    end
  endtask
  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ab", {rotary_a, rotary_b}, 2'b00);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pos", position, 0);
    chk("rst_ready4", ready4, 1);
    rst = 1'b0;
    issue(1'b1, 8'd1);
    watch(1'b1, 1);
    @(negedge clk);
    chk("cw1_done_low", done, 0);
    chk("cw1_pos", position, 16'h0001);
    issue(1'b1, 8'd3);
    repeat (10) @(negedge clk);
    chk("mid_ab_before_rst", {rotary_a, rotary_b}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ab", {rotary_a, rotary_b}, 2'b00);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pos", position, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_ab", {rotary_a, rotary_b}, 2'b00);
    end
    issue(1'b0, 8'd2);
    watch(1'b0, 2);
    @(negedge clk);
    chk("ccw2_done_low", done, 0);
    chk("ccw2_pos", position, 16'hFFFE);
    issue(1'b1, 8'd0);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_ab", {rotary_a, rotary_b}, 2'b00);
    @(negedge clk);
    chk("zero_done_low", done, 0);
    chk("zero_ab_after", {rotary_a, rotary_b}, 2'b00);
    chk("zero_pos", position, 16'hFFFE);
    @(negedge clk);
    cmd_dir = 1'b0;
    cmd_steps = 8'd1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_dir = 1'b1;
    cmd_steps = 8'd2;
    watch(1'b0, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    watch(1'b1, 2);
    @(negedge clk);
    chk("b2b_done_low", done, 0);
    chk("b2b_pos", position, 16'hFFFF);
    @(negedge clk);
    d4 = 1'b1;
    s4 = 8'd7;
    v4 = 1'b1;
    @(posedge clk);
    #1 v4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("wrap7_done", done4, 1);
    chk("wrap7_pos", pos4, 4'd7);
    @(negedge clk);
    s4 = 8'd9;
    v4 = 1'b1;
    @(posedge clk);
    #1 v4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("wrap9_done", done4, 1);
    chk("wrap9_pos", pos4, 4'd0);
    chk("wrap9_ab", {a4, b4}, 2'b00);
    chk("wrap9_busy", busy4, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
